// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select lines of an 8:1 mux, with one dead cycle after each release.
// Optional forced release after MAX_HOLD grant cycles is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       S2,
    output logic       S1,
    output logic       S0,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;

    logic [2:0] pick_idx;
    logic       pick_found;
    logic       release_req;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
    logic       expire;
`endif

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            logic [2:0] idx;
            idx = ptr_q + 3'(k);
            if (!pick_found && req[idx]) begin
                pick_idx   = idx;
                pick_found = 1'b1;
            end
        end
    end

    assign release_req = done || !req[sel_q];

`ifdef MUX_ARB_TIMEOUT_EN
    assign expire = (hold_cnt_q == 8'(MAX_HOLD - 1));
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
`ifdef MUX_ARB_TIMEOUT_EN
        timeout_d  = 1'b0;
        hold_cnt_d = (state_q == GRANT) ? hold_cnt_q + 8'd1 : '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = 8'b1 << pick_idx;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
`ifdef MUX_ARB_TIMEOUT_EN
                if (release_req || expire) begin
                    timeout_d = !release_req;
`else
                if (release_req) begin
`endif
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign {S2, S1, S0} = sel_q;
    assign valid        = valid_q;

`ifdef MUX_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // MAX_HOLD has no effect without the timeout feature.
    logic [7:0] max_hold_unused;
    assign max_hold_unused = 8'(MAX_HOLD);
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a driver pushes per-cycle expectations from a
// behavioural round-robin model; a monitor pops and compares after every rising edge.
module tb_mux8_rr_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       S2, S1, S0, valid, timeout;

    mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .S2(S2), .S1(S1), .S0(S0), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // Expected record: {gnt[7:0], sel[2:0], valid, timeout}
    logic [12:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model state: owner = -1 when nobody holds the mux.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_tmo   = 0;

    task automatic model_edge(input logic r, input logic [7:0] rq, input logic d);
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0; m_tmo = 0;
        end else if (m_owner < 0) begin
            m_tmo = 0;
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m_ptr + k) % 8;
                if (m_owner < 0 && rq[idx]) begin
                    m_owner = idx; m_sel = idx; m_hold = 1;
                end
            end
        end else begin
            m_tmo = 0;
            if (d || !rq[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1;
            end else if (TMO_EN && m_hold == MH) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_tmo = 1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic d);
        logic [7:0] g;
        @(negedge clk);
        rst_n = r; req = rq; done = d;
        model_edge(r, rq, d);
        g = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
        exp_q.push_back({g, 3'(m_sel), (m_owner >= 0), m_tmo});
    endtask

    // Monitor: one comparison per cycle that has a pending expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [12:0] e, a;
                e = exp_q.pop_front();
                a = {gnt, S2, S1, S0, valid, timeout};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t: got gnt=%h sel=%0d valid=%b timeout=%b, want gnt=%h sel=%0d valid=%b timeout=%b",
                             $time, a[12:5], a[4:2], a[1], a[0], e[12:5], e[4:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; done = 1'b0;

        // Reset then idle
        step(0, 8'h00, 0); step(0, 8'h00, 1);
        repeat (5) step(1, 8'h00, 1);

        // Alternating 0,7 with done one cycle after each grant
        repeat (4) begin
            step(1, 8'h81, 0);
            step(1, 8'h81, 1);
        end

        // Owner 3 holds while other requests rise, then successors wrap past 7
        step(0, 8'h00, 0);
        step(1, 8'h08, 0);
        repeat (3) step(1, 8'hFF, 0);
        step(1, 8'hFF, 1);
        repeat (5) begin
            step(1, 8'hFF, 0);
            step(1, 8'hFF, 1);
        end
        step(1, 8'hFF, 0);

        // Long hold on a single requester (forced release when enabled)
        step(0, 8'h00, 0);
        repeat (12) step(1, 8'h02, 0);
        // done coinciding with the would-be timeout cycle
        step(1, 8'h00, 0); step(1, 8'h00, 0);
        step(1, 8'h02, 0);
        repeat (MH - 1) step(1, 8'h02, 0);
        step(1, 8'h02, 1);
        step(1, 8'h02, 0);

        // Reset in the third cycle of a grant, then fresh arbitration from ptr 0
        step(0, 8'h00, 0);
        step(1, 8'h04, 0); step(1, 8'h04, 0); step(1, 8'h04, 0);
        step(0, 8'h04, 0);
        step(1, 8'h04, 0); step(1, 8'h04, 0);

        // Done ignored in IDLE; requester drop acts as release
        step(1, 8'h00, 1); step(1, 8'h20, 1); step(1, 8'h20, 0); step(1, 8'h00, 0);

        // Randomized traffic
        begin
            logic [7:0] rq;
            rq = 8'($urandom);
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
                step(($urandom_range(0, 99) != 0), rq, ($urandom_range(0, 5) == 0));
            end
        end

        @(negedge clk);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
